// File: rtl/dcache_pkg.sv
// Shared types and address-geometry helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RF   = 2'd2,
        ST_FILL = 2'd3
    } dc_state_e;

    localparam int WORD_W = 32;

    function automatic int off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bits);
        return addr_w - idx_w(sets) - off_w(line_bits);
    endfunction

endpackage

// File: rtl/dcache_way_store.sv
// One way of the cache: tag, valid, dirty and line storage with combinational read.
// Valid/dirty bits are reset; tag and data arrays are not.
module dcache_way_store
    import dcache_pkg::*;
#(
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 23,
    parameter int IDX_W     = 4,
    parameter int WSEL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 word_en,
    input  logic [WSEL_W-1:0]    word_sel,
    input  logic [WORD_W-1:0]    word_data,
    input  logic                 fill_en,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [LINE_BITS-1:0] fill_line
);

    logic [SETS-1:0]      valid_r;
    logic [SETS-1:0]      dirty_r;
    logic [TAG_W-1:0]     tag_r  [SETS];
    logic [LINE_BITS-1:0] data_r [SETS];

    assign rd_valid = valid_r[rd_idx];
    assign rd_dirty = dirty_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_line  = data_r[rd_idx];

    // Status bits: a fill installs a clean valid line, a store marks the line dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_en) begin
            valid_r[wr_idx] <= 1'b1;
            dirty_r[wr_idx] <= 1'b0;
        end else if (word_en) begin
            dirty_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and line payload: whole-line install on fill, single-word update on store hit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[wr_idx]  <= fill_tag;
            data_r[wr_idx] <= fill_line;
        end else if (word_en) begin
            data_r[wr_idx][int'(word_sel) * WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache with tree pseudo-LRU replacement.
// Misses stall the pipeline, optionally write back a dirty victim, refill, then replay.
// Optional hit/miss counters are enabled by defining DCACHE_ASSOC_STATS_EN.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [WORD_W-1:0]    p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [WORD_W-1:0]    p1_data_o,
    output logic                 p1_stall_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_ASSOC_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int OFF_W  = off_w(LINE_BITS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BITS);
    localparam int WSEL_W = $clog2(LINE_BITS / WORD_W);
    localparam int LVL    = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LVL : 1;

    // Tree PLRU: node n (1..WAYS-1) steers to child 2n+bit; leaves WAYS..2*WAYS-1 are ways.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] t);
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) node = 2 * node + int'(t[node]);
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t, input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] r;
        int node;
        int leaf;
        int b;
        r    = t;
        node = 1;
        leaf = WAYS + int'(w);
        for (int l = LVL - 1; l >= 0; l--) begin
            b       = (leaf >> l) & 1;
            r[node] = (b == 0) ? 1'b1 : 1'b0;
            node    = 2 * node + b;
        end
        return r;
    endfunction

    dc_state_e            state_r;
    logic [TAG_W-1:0]     req_tag_r;
    logic [IDX_W-1:0]     req_idx_r;
    logic [WAY_W-1:0]     victim_r;
    logic [LINE_BITS-1:0] fill_line_r;
    logic [WAYS-1:0]      plru_r [SETS];

    logic [TAG_W-1:0]     in_tag_s;
    logic [IDX_W-1:0]     in_idx_s;
    logic [WSEL_W-1:0]    in_word_s;
    logic                 lookup_s;
    logic [WAYS-1:0]      way_valid_s;
    logic [WAYS-1:0]      way_dirty_s;
    logic [TAG_W-1:0]     way_tag_s  [WAYS];
    logic [LINE_BITS-1:0] way_line_s [WAYS];
    logic [WAYS-1:0]      hit_vec_s;
    logic                 hit_s;
    logic [WAY_W-1:0]     hit_way_s;
    logic [WAY_W-1:0]     victim_s;
    logic [WORD_W-1:0]    hit_word_s;
    logic [IDX_W-1:0]     wr_idx_s;

    assign in_tag_s  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign in_idx_s  = p1_addr_i[OFF_W +: IDX_W];
    assign in_word_s = p1_addr_i[2 +: WSEL_W];
    assign lookup_s  = (state_r == ST_IDLE) && (p1_MemRead_i || p1_MemWrite_i);
    assign wr_idx_s  = (state_r == ST_FILL) ? req_idx_r : in_idx_s;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dcache_way_store #(
            .SETS(SETS), .LINE_BITS(LINE_BITS), .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W)
        ) u_store (
            .clk       (clk_i),
            .rst_n     (rst_i),
            .rd_idx    (in_idx_s),
            .rd_valid  (way_valid_s[g]),
            .rd_dirty  (way_dirty_s[g]),
            .rd_tag    (way_tag_s[g]),
            .rd_line   (way_line_s[g]),
            .wr_idx    (wr_idx_s),
            .word_en   (lookup_s && hit_s && p1_MemWrite_i && (hit_way_s == WAY_W'(g))),
            .word_sel  (in_word_s),
            .word_data (p1_data_i),
            .fill_en   ((state_r == ST_FILL) && (victim_r == WAY_W'(g))),
            .fill_tag  (req_tag_r),
            .fill_line (fill_line_r)
        );
    end

    // Parallel tag compare across all ways; lowest matching way wins.
    always_comb begin
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = way_valid_s[w] && (way_tag_s[w] == in_tag_s);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
        hit_s      = |hit_vec_s;
        hit_word_s = way_line_s[hit_way_s][int'(in_word_s) * WORD_W +: WORD_W];
    end

    // Victim choice: lowest invalid way first, otherwise the PLRU pointer.
    always_comb begin
        victim_s = plru_victim(plru_r[in_idx_s]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_s = way_valid_s[w] ? victim_s : WAY_W'(w);
        end
    end

    // Load data and stall must respond in the lookup cycle; reset forces both low.
    assign p1_data_o  = (lookup_s && hit_s && p1_MemRead_i && !p1_MemWrite_i) ? hit_word_s : '0;
    assign p1_stall_o = rst_i && ((state_r != ST_IDLE) ||
                                  ((p1_MemRead_i || p1_MemWrite_i) && !hit_s));

    // Miss handler: write back dirty victim, refill, install, then replay in IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            req_tag_r    <= '0;
            req_idx_r    <= '0;
            victim_r     <= '0;
            fill_line_r  <= '0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lookup_s && !hit_s) begin
                        req_tag_r    <= in_tag_s;
                        req_idx_r    <= in_idx_s;
                        victim_r     <= victim_s;
                        mem_enable_o <= 1'b1;
                        if (way_valid_s[victim_s] && way_dirty_s[victim_s]) begin
                            state_r     <= ST_WB;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {way_tag_s[victim_s], in_idx_s, {OFF_W{1'b0}}};
                            mem_data_o  <= way_line_s[victim_s];
                        end else begin
                            state_r     <= ST_RF;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {in_tag_s, in_idx_s, {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ack_i) begin
                        state_r     <= ST_RF;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
                    end
                end
                ST_RF: begin
                    if (mem_ack_i) begin
                        state_r      <= ST_FILL;
                        fill_line_r  <= mem_data_i;
                        mem_enable_o <= 1'b0;
                    end
                end
                ST_FILL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                end
            endcase
        end
    end

    // Replacement state: point away from the way just hit or just filled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) plru_r[s] <= '0;
        end else if (state_r == ST_FILL) begin
            plru_r[req_idx_r] <= plru_touch(plru_r[req_idx_r], victim_r);
        end else if (lookup_s && hit_s) begin
            plru_r[in_idx_s] <= plru_touch(plru_r[in_idx_s], hit_way_s);
        end
    end

`ifdef DCACHE_ASSOC_STATS_EN
    logic replay_r;

    // Flags the IDLE cycle right after FILL so the replayed hit is not counted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            replay_r <= 1'b0;
        end else begin
            replay_r <= (state_r == ST_FILL);
        end
    end

    // Saturating first-lookup hit and miss counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
        end else if (lookup_s && !replay_r) begin
            if (hit_s) begin
                hit_cnt_o <= (hit_cnt_o == 32'hFFFF_FFFF) ? hit_cnt_o : hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= (miss_cnt_o == 32'hFFFF_FFFF) ? miss_cnt_o : miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways (power of two, 1..8).
REQ-002 SHALL have parameter SETS, default 16, sets per way (power of two).
REQ-003 SHALL have parameter LINE_BITS, default 256, line width; word 32 bits, offset width log2(LINE_BITS/8).
REQ-004 SHALL have parameter ADDR_W, default 32, byte-address width; tag = ADDR_W - index - offset bits.
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 p1_addr_i  in  ADDR_W  CPU byte address, word-aligned.
REQ-008 p1_data_i  in  32  CPU store data.
REQ-009 p1_MemRead_i  in  1  load request.
REQ-010 p1_MemWrite_i  in  1  store request.
REQ-011 p1_data_o  out  32  load data.
REQ-012 p1_stall_o  out  1  pipeline stall.
REQ-013 mem_addr_o  out  ADDR_W  line address, offset bits zero.
REQ-014 mem_data_o  out  LINE_BITS  write-back line.
REQ-015 mem_enable_o  out  1  memory request.
REQ-016 mem_write_o  out  1  1 = write-back, 0 = refill.
REQ-017 mem_data_i  in  LINE_BITS  refill line.
REQ-018 mem_ack_i  in  1  one-cycle completion pulse.

Function
REQ-019 Lookup SHALL be combinational on all ways of set index; hit = valid and tag match in any way.
REQ-020 Read hit SHALL drive p1_data_o in same cycle with p1_stall_o=0; write hit SHALL update the word and set dirty at the next edge.
REQ-021 Request with no hit SHALL raise p1_stall_o combinationally in the same cycle and hold it until the replayed access hits.
REQ-022 FSM states SHALL be IDLE, WB (dirty victim write-back), RF (refill), FILL (install line), returning to IDLE.
REQ-023 Transitions: IDLE->WB on miss with dirty victim; IDLE->RF on miss with clean or invalid victim; WB->RF on mem_ack_i; RF->FILL on mem_ack_i; FILL->IDLE unconditionally.
REQ-024 In WB/RF, mem_enable_o SHALL stay 1 until mem_ack_i; mem_write_o=1 only in WB; mem_addr_o = victim tag+index in WB, request tag+index in RF.
REQ-025 FILL SHALL write mem_data_i (latched at ack) into victim way, valid=1, dirty=0; the replay then completes as a normal hit.
REQ-026 Victim SHALL be the lowest-numbered invalid way, else tree pseudo-LRU; WAYS=1 degenerates to direct-mapped.
REQ-027 PLRU bits SHALL update on every hit and on FILL, pointing away from the accessed way.
REQ-028 MemRead and MemWrite both asserted SHALL be treated as a write.
REQ-029 mem_ack_i outside WB/RF SHALL be ignored.
REQ-030 Requests SHALL be sampled only in IDLE; input changes during a miss are not required to be tracked.

Reset
REQ-031 Reset low SHALL, from any state including mid-miss, force IDLE, clear all valid, dirty and PLRU bits; outputs p1_stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0.
REQ-032 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-033 Macro DCACHE_ASSOC_STATS_EN defined: ports hit_cnt_o and miss_cnt_o (32-bit, out) SHALL count first-lookup hits and misses, saturating at 0xFFFFFFFF, cleared by reset; replay hits not counted.
REQ-034 Undefined: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-035 Package dcache_pkg SHALL hold the FSM state typedef, word width constant, and offset/index/tag width functions.
REQ-036 Per-way tag/valid/dirty/data storage SHALL be sub-module dcache_way_store, instantiated WAYS times.

Verification
REQ-037 Cold read 0x100: stall=1, RF issues mem_addr_o=0x100, ack with line word0=0xDEADBEEF -> after FILL p1_data_o=0xDEADBEEF, stall=0.
REQ-038 Write 0x55 to 0x104 (hit) then read 0x104 -> 0x55, no stall, no memory request.
REQ-039 WAYS=2, SETS=16: fill 0x000, 0x200, dirty write to 0x000, touch 0x200, read 0x400 -> WB of 0x000 with written word, then RF 0x400.
REQ-040 Reset low during RF with mem_enable_o=1 -> enable drops immediately; later read 0x100 misses again.
REQ-041 Stray mem_ack_i in IDLE -> no state change, no array write.
REQ-042 With DCACHE_ASSOC_STATS_EN: scenarios 037+038 -> miss_cnt_o=1, hit_cnt_o=2.
